// File: rtl/spi_serial_tx_pkg.sv
// Shared definitions for the SPI master transmitter: frame defaults, FSM encoding
// and a counter-width helper used by the top and the tick generator.
package spi_serial_tx_pkg;

    localparam int FRAME_W_DEF = 48;
    localparam int CLK_DIV_DEF = 4;
    localparam int CS_GAP_DEF  = 8;

    // Encodings match those used by SPI_Serial users.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_serial_tx_tick_gen.sv
// Half-period tick generator: down-counter that fires one tick every CLK_DIV
// clk cycles while enabled, with the first tick CLK_DIV cycles after enable rises.
module spi_serial_tx_tick_gen
    import spi_serial_tx_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (!en || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_serial_tx.sv
// SPI mode-0 master transmitter: sends one FRAME_W-bit word MSB-first per accept,
// framed by active-low spi_cs, all pin outputs registered.
//
// state | meaning
// IDLE  | waiting for tx_valid, tx_ready high
// SETUP | cs low, first bit on spi_out, waiting one half-period before first rise
// SHIFT | toggling spi_clk, new bit on every fall except the last
// HOLD  | last fall done, cs held low for one half-period
// GAP   | cs high for CS_GAP cycles before returning to IDLE
module spi_serial_tx
    import spi_serial_tx_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int CS_GAP  = CS_GAP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               busy,
    output logic               done,
    output logic               spi_clk,
    output logic               spi_cs,
    output logic               spi_out
);

    localparam int BW = cnt_width(FRAME_W);
    localparam int GW = cnt_width(CS_GAP);
    localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_W - 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(CS_GAP - 1);

    tx_state_e          state;
    logic [FRAME_W-2:0] shift_reg;
    logic [BW-1:0]      bit_cnt;
    logic               last_bit;
    logic [GW-1:0]      gap_cnt;
    logic               tick;

    spi_serial_tx_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state != ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            last_bit  <= 1'b0;
            gap_cnt   <= '0;
            spi_clk   <= 1'b0;
            spi_cs    <= 1'b1;
            spi_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_ready  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift_reg <= tx_data[FRAME_W-2:0];
                        spi_out   <= tx_data[FRAME_W-1];
                        spi_cs    <= 1'b0;
                        busy      <= 1'b1;
                        tx_ready  <= 1'b0;
                        bit_cnt   <= '0;
                        last_bit  <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        spi_clk  <= 1'b1;
                        last_bit <= (bit_cnt == LAST_BIT);
                        if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!spi_clk) begin
                            spi_clk  <= 1'b1;
                            last_bit <= (bit_cnt == LAST_BIT);
                            if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            spi_clk <= 1'b0;
                            // last_bit marks that the final rise has already happened
                            if (last_bit) begin
                                spi_out <= 1'b0;
                                state   <= ST_HOLD;
                            end else begin
                                spi_out   <= shift_reg[FRAME_W-2];
                                shift_reg <= {shift_reg[FRAME_W-3:0], 1'b0};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        spi_cs  <= 1'b1;
                        gap_cnt <= GAP_RELOAD;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
